// File: rtl/pid_pkg.sv
// Shared types and helpers for the multi-cycle PID controller.
// Holds the sequencer state encoding, default widths and the overflow
// classifier used by every signed saturator in the datapath.
package pid_pkg;

  localparam int DEF_DW   = 16;
  localparam int DEF_FRAC = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ERR   = 3'd1,
    ST_MUL_P = 3'd2,
    ST_MUL_I = 3'd3,
    ST_MUL_D = 3'd4,
    ST_SUM   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SAT_NONE = 2'b00,
    SAT_POS  = 2'b01,
    SAT_NEG  = 2'b10
  } sat_dir_t;

  // A signed value fits the narrower width when every bit above the new sign
  // bit equals it; otherwise it clips toward the side its sign points to.
  function automatic sat_dir_t sat_dir(input logic sign_bit, input logic top_all_same);
    if (top_all_same) begin
      return SAT_NONE;
    end else if (sign_bit) begin
      return SAT_NEG;
    end else begin
      return SAT_POS;
    end
  endfunction

endpackage

// File: rtl/pid_sat.sv
// Signed saturator: clips a signed IN_W value into the signed OUT_W range.
// Purely combinational; IN_W must be greater than OUT_W.
module pid_sat
  import pid_pkg::*;
#(
  parameter int IN_W  = 17,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  logic [IN_W-OUT_W:0] top;
  logic                top_same;
  sat_dir_t            dir;

  // Inspect the bits that would be dropped and pick the clipped or passed value
  always_comb begin
    top      = din[IN_W-1:OUT_W-1];
    top_same = (&top) | ~(|top);
    dir      = sat_dir(din[IN_W-1], top_same);
    case (dir)
      SAT_POS: dout = {1'b0, {(OUT_W-1){1'b1}}};
      SAT_NEG: dout = {1'b1, {(OUT_W-1){1'b0}}};
      default: dout = din[OUT_W-1:0];
    endcase
  end

endmodule

// File: rtl/pid_controller_param.sv
// Multi-cycle PID controller: one shared signed multiplier sequenced by a
// six-state FSM, result registered 5 edges after the sample is captured.
// Anti-windup integrator clamp, saturated output, overrun flag on dropped ticks.
module pid_controller_param
  import pid_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int FRAC = DEF_FRAC,
  parameter int ACCW = 2*DW+4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clear,
  input  logic signed [DW-1:0] setpoint,
  input  logic signed [DW-1:0] feedback,
  input  logic signed [DW-1:0] kp,
  input  logic signed [DW-1:0] ki,
  input  logic signed [DW-1:0] kd,
  input  logic [ACCW-2:0]      int_limit,
  input  logic [15:0]          clk_times,
  output logic signed [DW-1:0] control_signal,
  output logic                 valid,
  output logic                 busy,
  output logic                 overrun
);

  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic signed [DW-1:0]  sp_q, sp_d;
  logic signed [DW-1:0]  fb_q, fb_d;
  logic signed [DW-1:0]  e_q, e_d;
  logic signed [DW-1:0]  prev_e_q, prev_e_d;
  logic signed [ACCW-1:0] p_q, p_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [ACCW-1:0] dterm_q, dterm_d;
  logic signed [DW-1:0]  ctrl_q, ctrl_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;

  logic                  tick;
  logic signed [DW:0]    err_raw;
  logic signed [DW-1:0]  err_sat;
  logic signed [DW:0]    de_raw;
  logic signed [DW-1:0]  de_sat;
  logic signed [DW-1:0]  mul_a, mul_b;
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW:0]  acc_sum, lim_pos, lim_neg, acc_clamp;
  logic signed [ACCW-1:0] sum_s;
  logic signed [ACCW-FRAC-1:0] sum_shift;
  logic signed [DW-1:0]  out_sat;
  logic                  unused_bits;

  // Error and derivative delta are computed one bit wider, then clipped back to DW
  pid_sat #(.IN_W(DW+1), .OUT_W(DW)) u_sat_err (.din(err_raw), .dout(err_sat));
  pid_sat #(.IN_W(DW+1), .OUT_W(DW)) u_sat_de  (.din(de_raw),  .dout(de_sat));
  pid_sat #(.IN_W(ACCW-FRAC), .OUT_W(DW)) u_sat_out (.din(sum_shift), .dout(out_sat));

  // The clamp result always fits ACCW, and the fraction bits are shifted away
  assign unused_bits = ^{acc_clamp[ACCW], sum_s[FRAC-1:0]};

  // State and datapath registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sp_q      <= '0;
      fb_q      <= '0;
      e_q       <= '0;
      prev_e_q  <= '0;
      p_q       <= '0;
      acc_q     <= '0;
      dterm_q   <= '0;
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sp_q      <= sp_d;
      fb_q      <= fb_d;
      e_q       <= e_d;
      prev_e_q  <= prev_e_d;
      p_q       <= p_d;
      acc_q     <= acc_d;
      dterm_q   <= dterm_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Sequencer next state: one cycle per stage, a new sample only starts from IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (tick) state_d = ST_ERR;
      ST_ERR:   state_d = ST_MUL_P;
      ST_MUL_P: state_d = ST_MUL_I;
      ST_MUL_I: state_d = ST_MUL_D;
      ST_MUL_D: state_d = ST_SUM;
      ST_SUM:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Sequencer outputs: busy flag and the shared multiplier operand select
  always_comb begin
    busy  = (state_q != ST_IDLE);
    mul_a = kp;
    mul_b = e_q;
    case (state_q)
      ST_MUL_I: begin
        mul_a = ki;
        mul_b = e_q;
      end
      ST_MUL_D: begin
        mul_a = kd;
        mul_b = de_sat;
      end
      default: begin
        mul_a = kp;
        mul_b = e_q;
      end
    endcase
  end

  // Sample counter, shared multiplier and the per-stage register updates
  always_comb begin
    tick    = en && (cnt_q == clk_times);
    cnt_d   = (!en || tick) ? 16'd0 : cnt_q + 16'd1;

    err_raw = {sp_q[DW-1], sp_q} - {fb_q[DW-1], fb_q};
    de_raw  = {e_q[DW-1], e_q} - {prev_e_q[DW-1], prev_e_q};

    // Sign-extended operands keep the low 2*DW bits of the product signed-correct
    prod     = {{DW{mul_a[DW-1]}}, mul_a} * {{DW{mul_b[DW-1]}}, mul_b};
    prod_ext = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};

    // One extra bit so the integrator sum cannot wrap before it is clamped
    acc_sum = {acc_q[ACCW-1], acc_q} + {prod_ext[ACCW-1], prod_ext};
    lim_pos = {2'b00, int_limit};
    lim_neg = -lim_pos;
    if (acc_sum > lim_pos) begin
      acc_clamp = lim_pos;
    end else if (acc_sum < lim_neg) begin
      acc_clamp = lim_neg;
    end else begin
      acc_clamp = acc_sum;
    end

    // Dropping the low FRAC bits of a two's complement value is a floor shift
    sum_s     = p_q + acc_q + dterm_q;
    sum_shift = sum_s[ACCW-1:FRAC];

    sp_d      = sp_q;
    fb_d      = fb_q;
    e_d       = e_q;
    prev_e_d  = prev_e_q;
    p_d       = p_q;
    acc_d     = acc_q;
    dterm_d   = dterm_q;
    ctrl_d    = ctrl_q;
    valid_d   = (state_q == ST_SUM);
    overrun_d = tick && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          sp_d = setpoint;
          fb_d = feedback;
        end
      end
      ST_ERR:   e_d = err_sat;
      ST_MUL_P: p_d = prod_ext;
      ST_MUL_I: acc_d = acc_clamp[ACCW-1:0];
      ST_MUL_D: begin
        dterm_d  = prod_ext;
        prev_e_d = e_q;
      end
      ST_SUM:   ctrl_d = out_sat;
      default: ;
    endcase

    // Clear overrides any integrator or history update in the same cycle
    if (clear) begin
      acc_d    = '0;
      prev_e_d = '0;
    end
  end

  assign control_signal = ctrl_q;
  assign valid          = valid_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_pid_controller_param.sv
// Directed bench for pid_controller_param with hand-computed expectations.
module tb_pid_controller_param;

  localparam int DW   = 16;
  localparam int FRAC = 8;
  localparam int ACCW = 2*DW+4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 clear;
  logic signed [DW-1:0] setpoint;
  logic signed [DW-1:0] feedback;
  logic signed [DW-1:0] kp;
  logic signed [DW-1:0] ki;
  logic signed [DW-1:0] kd;
  logic [ACCW-2:0]      int_limit;
  logic [15:0]          clk_times;
  logic signed [DW-1:0] control_signal;
  logic                 valid;
  logic                 busy;
  logic                 overrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pid_controller_param #(.DW(DW), .FRAC(FRAC), .ACCW(ACCW)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .clear          (clear),
    .setpoint       (setpoint),
    .feedback       (feedback),
    .kp             (kp),
    .ki             (ki),
    .kd             (kd),
    .int_limit      (int_limit),
    .clk_times      (clk_times),
    .control_signal (control_signal),
    .valid          (valid),
    .busy           (busy),
    .overrun        (overrun)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next valid pulse; check its latency and value
  task automatic sample(input string tag, input int exp_lat, input int exp_val);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 40);
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_val"}, control_signal, exp_val);
  endtask

  // Stop sampling, let the pipeline drain, clear history, restart the counter
  task automatic restart(input logic [15:0] ct);
    int n = 0;
    en = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || valid) && n < 20);
    check("drain_busy", busy, 0);
    clear = 1'b1;
    @(negedge clk);
    clear     = 1'b0;
    clk_times = ct;
    en        = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int nv;
    int no;
    int ivals[5];
    rst       = 1'b1;
    en        = 1'b0;
    clear     = 1'b0;
    setpoint  = '0;
    feedback  = '0;
    kp        = '0;
    ki        = '0;
    kd        = '0;
    int_limit = 35'h0_0010_0000;
    clk_times = 16'd9;
    repeat (3) @(negedge clk);
    check("rst_ctrl", control_signal, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;

    // Proportional only: e=60, kp=1.0
    kp = 16'h0100; ki = '0; kd = '0; setpoint = 16'sd100; feedback = 16'sd40;
    restart(16'd9);
    sample("p1", 15, 60);
    @(negedge clk);
    check("p_valid_pulse", valid, 0);
    repeat (3) @(negedge clk);
    check("p_busy_lo", busy, 0);
    @(negedge clk);
    check("p_busy_hi", busy, 1);
    sample("p2", 5, 60);
    sample("p3", 10, 60);

    // Integral only: ki=0.5, e=10 adds 1280 per sample, then both clamps
    kp = '0; ki = 16'h0080; kd = '0; setpoint = 16'sd10; feedback = '0;
    restart(16'd9);
    sample("i1", 15, 5);
    sample("i2", 10, 10);
    sample("i3", 10, 15);
    sample("i4", 10, 20);
    int_limit = 35'h0A00;
    sample("i5", 10, 10);
    sample("i6", 10, 10);
    setpoint = -16'sd10;
    ivals = '{5, 0, -5, -10, -10};
    for (int i = 0; i < 5; i++) begin
      sample("i_neg", 10, ivals[i]);
    end
    int_limit = 35'h0_0010_0000;

    // Derivative only: e = 0, 20, 20, then clear drops history before another 20
    kp = '0; ki = '0; kd = 16'h0100; setpoint = '0; feedback = '0;
    restart(16'd9);
    sample("d1", 15, 0);
    setpoint = 16'sd20;
    sample("d2", 10, 20);
    sample("d3", 10, 0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    sample("d4", 9, 20);

    // Error and output saturation, plus floor rounding of a negative result
    kp = 16'h7FFF; ki = '0; kd = '0; setpoint = 16'sd1000; feedback = '0;
    restart(16'd9);
    sample("s1", 15, 32767);
    setpoint = -16'sd1000;
    sample("s2", 10, -32768);
    setpoint = 16'sd32767; feedback = -16'sd32768;
    sample("s3", 10, 32767);
    kp = 16'h0080; setpoint = -16'sd3; feedback = '0;
    sample("s4", 10, -2);
    kp = 16'h0100; setpoint = -16'sd32768; feedback = 16'sd32767;
    sample("s5", 10, -32768);

    // Period of 3 cycles: every other tick dropped with an overrun pulse
    kp = 16'h0100; ki = '0; kd = '0; setpoint = 16'sd50; feedback = '0;
    restart(16'd2);
    nv = 0;
    no = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (valid) begin
        nv++;
        check("ovr_val", control_signal, 50);
      end
      if (overrun) no++;
    end
    check("ovr_valids", nv, 9);
    check("ovr_drops", no, 10);

    // Reset while the integrator stage is active
    kp = 16'h0100; ki = 16'h0080; kd = '0; setpoint = 16'sd30; feedback = '0;
    restart(16'd9);
    sample("r1", 15, 45);
    repeat (7) @(negedge clk);
    check("r_busy_mul_i", busy, 1);
    rst = 1'b1;
    #1;
    check("r_ctrl", control_signal, 0);
    check("r_valid", valid, 0);
    check("r_busy", busy, 0);
    check("r_overrun", overrun, 0);
    check("r_acc", dut.acc_q, 0);
    @(negedge clk);
    check("r_valid_hold", valid, 0);
    rst = 1'b0;
    sample("r2", 15, 45);
    sample("r3", 10, 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
